// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//
// Purpose:
//   Bundles the issue handshake, the writeback result handshake and the
//   fetch redirect handshake of the branch resolve unit into one interface.
//
// Signal summary:
//   Issue    : in_valid / in_ready, in_pc, in_inst, in_aluop, in_rj_data,
//              in_rd_data, in_wb_addr, in_pred_taken, in_pred_target
//   Result   : out_valid / out_ready, out_wb_en, out_wb_addr, out_wb_data,
//              out_mispredict
//   Redirect : redirect_valid / redirect_ready, redirect_pc
//
// Modports:
//   master : the pipeline side (drives issue fields, accepts results)
//   slave  : the branch resolve unit itself
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [7:0]  in_aluop;
    logic [31:0] in_rj_data;
    logic [31:0] in_rd_data;
    logic [4:0]  in_wb_addr;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;

    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic [4:0]  out_wb_addr;
    logic [31:0] out_wb_data;
    logic        out_mispredict;

    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    modport master (
        output in_valid, in_pc, in_inst, in_aluop, in_rj_data, in_rd_data,
               in_wb_addr, in_pred_taken, in_pred_target,
               out_ready, redirect_ready,
        input  in_ready, out_valid, out_wb_en, out_wb_addr, out_wb_data,
               out_mispredict, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_aluop, in_rj_data, in_rd_data,
               in_wb_addr, in_pred_taken, in_pred_target,
               out_ready, redirect_ready,
        output in_ready, out_valid, out_wb_en, out_wb_addr, out_wb_data,
               out_mispredict, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Resolves a decoded branch (direction, target, link writeback), compares
//   it with the fetch prediction and raises a fetch redirect on mispredict.
//   Results are registered: an accepted branch shows up on out_valid exactly
//   one cycle later. The writeback result and the redirect are separate
//   handshakes that may complete in either order; no new branch is accepted
//   while a redirect is still pending.
//
// Ports:
//   clk    : single clock, rising edge
//   rst    : asynchronous, active-high reset
//   flush  : kills all pending results and drops a same-cycle issue
//   bru    : branch_resolve_unit_if.slave (issue / result / redirect)
//
// Optional feature (macro BRANCH_STAT_EN):
//   Adds stat_branch_cnt[31:0] and stat_mispredict_cnt[31:0] outputs that
//   count accepted branches and mispredicts. They wrap, clear only on rst
//   and are unaffected by flush. Without the macro they do not exist.
// ---------------------------------------------------------------------------
module branch_resolve_unit (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    branch_resolve_unit_if.slave bru
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0]          stat_branch_cnt,
    output logic [31:0]          stat_mispredict_cnt
`endif
);

    // ALU operation codes shared with the decoder.
    localparam logic [7:0] ALU_BEQ  = 8'h10;
    localparam logic [7:0] ALU_BNE  = 8'h11;
    localparam logic [7:0] ALU_BLT  = 8'h12;
    localparam logic [7:0] ALU_BGE  = 8'h13;
    localparam logic [7:0] ALU_BLTU = 8'h14;
    localparam logic [7:0] ALU_BGEU = 8'h15;
    localparam logic [7:0] ALU_B    = 8'h16;
    localparam logic [7:0] ALU_BL   = 8'h17;
    localparam logic [7:0] ALU_JIRL = 8'h18;

    // BL always links into r1.
    localparam logic [4:0] LINK_REG = 5'd1;

    typedef enum logic [1:0] {
        IDLE,
        RESULT,
        REDIR
    } state_t;

    state_t      state;

    logic        out_valid_q;
    logic        out_wb_en_q;
    logic [4:0]  out_wb_addr_q;
    logic [31:0] out_wb_data_q;
    logic        out_mispredict_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        in_ready_int;
    logic        accept;
    logic        out_done;
    logic        redir_done;
    logic        out_left;
    logic        redir_left;

    logic [15:0] offs16;
    logic [25:0] offs26;
    logic [31:0] offs16_sext;
    logic [31:0] offs26_sext;
    logic [31:0] pc_plus4;
    logic        operands_eq;
    logic        signed_lt;
    logic        unsigned_lt;

    logic        res_taken;
    logic [31:0] res_target;
    logic        res_wb_en;
    logic [4:0]  res_wb_addr;
    logic        res_mispredict;
    logic [31:0] res_redirect_pc;

    // The opcode field is already decoded into in_aluop.
    logic        unused_inst_bits;
    assign unused_inst_bits = &{1'b0, bru.in_inst[31:26]};

    // Immediate fields; both offsets are word offsets, hence the 2'b00.
    assign offs16      = bru.in_inst[25:10];
    assign offs26      = {bru.in_inst[9:0], bru.in_inst[25:10]};
    assign offs16_sext = {{14{offs16[15]}}, offs16, 2'b00};
    assign offs26_sext = {{4{offs26[25]}}, offs26, 2'b00};
    assign pc_plus4    = bru.in_pc + 32'd4;

    assign operands_eq = (bru.in_rj_data == bru.in_rd_data);
    assign signed_lt   = ($signed(bru.in_rj_data) < $signed(bru.in_rd_data));
    assign unsigned_lt = (bru.in_rj_data < bru.in_rd_data);

    // Direction, target and link decision for the branch in the issue slot.
    // Unknown opcodes resolve as not taken with no writeback.
    always_comb begin
        res_taken   = 1'b0;
        res_target  = bru.in_pc + offs16_sext;
        res_wb_en   = 1'b0;
        res_wb_addr = bru.in_wb_addr;
        case (bru.in_aluop)
            ALU_BEQ:  res_taken = operands_eq;
            ALU_BNE:  res_taken = !operands_eq;
            ALU_BLT:  res_taken = signed_lt;
            ALU_BGE:  res_taken = !signed_lt;
            ALU_BLTU: res_taken = unsigned_lt;
            ALU_BGEU: res_taken = !unsigned_lt;
            ALU_B: begin
                res_taken  = 1'b1;
                res_target = bru.in_pc + offs26_sext;
            end
            ALU_BL: begin
                res_taken   = 1'b1;
                res_target  = bru.in_pc + offs26_sext;
                res_wb_en   = 1'b1;
                res_wb_addr = LINK_REG;
            end
            ALU_JIRL: begin
                res_taken  = 1'b1;
                res_target = bru.in_rj_data + offs16_sext;
                // Writes to r0 are discarded.
                res_wb_en  = (bru.in_wb_addr != 5'd0);
            end
            default: begin
                res_taken = 1'b0;
            end
        endcase
    end

    // A correct "taken" prediction still mispredicts if fetch went to the
    // wrong place.
    assign res_mispredict  = (res_taken != bru.in_pred_taken) |
                             (res_taken & bru.in_pred_taken &
                              (res_target != bru.in_pred_target));
    assign res_redirect_pc = res_taken ? res_target : pc_plus4;

    // Accept only when nothing would be overwritten: no pending redirect and
    // the current result is either absent or leaving this cycle.
    assign in_ready_int = !rst & !flush & !redirect_valid_q &
                          (!out_valid_q | bru.out_ready);
    assign accept       = bru.in_valid & in_ready_int;

    assign out_done   = out_valid_q & bru.out_ready;
    assign redir_done = redirect_valid_q & bru.redirect_ready;
    assign out_left   = out_valid_q & !out_done;
    assign redir_left = redirect_valid_q & !redir_done;

    // Control FSM with all result registers. flush wins over every
    // handshake; in REDIR the two handshakes retire independently and the
    // unit returns to IDLE only once both are gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            out_valid_q      <= 1'b0;
            out_wb_en_q      <= 1'b0;
            out_wb_addr_q    <= 5'd0;
            out_wb_data_q    <= 32'd0;
            out_mispredict_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else if (flush) begin
            state            <= IDLE;
            out_valid_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q      <= 1'b1;
            out_wb_en_q      <= res_wb_en;
            out_wb_addr_q    <= res_wb_addr;
            out_wb_data_q    <= pc_plus4;
            out_mispredict_q <= res_mispredict;
            redirect_valid_q <= res_mispredict;
            redirect_pc_q    <= res_redirect_pc;
            state            <= res_mispredict ? REDIR : RESULT;
        end else begin
            out_mispredict_q <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RESULT: begin
                    out_valid_q <= out_left;
                    state       <= out_left ? RESULT : IDLE;
                end
                REDIR: begin
                    out_valid_q      <= out_left;
                    redirect_valid_q <= redir_left;
                    state            <= (out_left | redir_left) ? REDIR : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STAT_EN
    // Performance counters survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branch_cnt     <= 32'd0;
            stat_mispredict_cnt <= 32'd0;
        end else if (accept) begin
            stat_branch_cnt <= stat_branch_cnt + 32'd1;
            if (res_mispredict) begin
                stat_mispredict_cnt <= stat_mispredict_cnt + 32'd1;
            end
        end
    end
`endif

    assign bru.in_ready       = in_ready_int;
    assign bru.out_valid      = out_valid_q;
    assign bru.out_wb_en      = out_wb_en_q;
    assign bru.out_wb_addr    = out_wb_addr_q;
    assign bru.out_wb_data    = out_wb_data_q;
    assign bru.out_mispredict = out_mispredict_q;
    assign bru.redirect_valid = redirect_valid_q;
    assign bru.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Scoreboard bench for branch_resolve_unit. The main process issues directed
// and random branches; a negedge monitor pushes the reference model's
// expectation on every accept and checks results, redirects, mispredict
// pulses and in_ready as the DUT presents them. Optional counters are
// checked when BRANCH_STAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam logic [7:0] ALU_BEQ  = 8'h10;
    localparam logic [7:0] ALU_BNE  = 8'h11;
    localparam logic [7:0] ALU_BLT  = 8'h12;
    localparam logic [7:0] ALU_BGE  = 8'h13;
    localparam logic [7:0] ALU_BLTU = 8'h14;
    localparam logic [7:0] ALU_BGEU = 8'h15;
    localparam logic [7:0] ALU_B    = 8'h16;
    localparam logic [7:0] ALU_BL   = 8'h17;
    localparam logic [7:0] ALU_JIRL = 8'h18;

    typedef struct {
        logic        mp;
        logic [31:0] target;
        logic [31:0] rpc;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 1;
    bit   fresh = 0;

    exp_t        res_q[$];
    logic [31:0] redir_q[$];

    branch_resolve_unit_if bus();

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_mispredict_cnt;
    logic [31:0] exp_bcnt = 0;
    logic [31:0] exp_mcnt = 0;
`endif

    branch_resolve_unit dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bru   (bus)
`ifdef BRANCH_STAT_EN
        ,
        .stat_branch_cnt     (stat_branch_cnt),
        .stat_mispredict_cnt (stat_mispredict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: plain arithmetic from the instruction semantics.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst,
                                   input logic [7:0] op, input logic [31:0] rj,
                                   input logic [31:0] rd, input logic [4:0] wa,
                                   input logic pt, input logic [31:0] ptgt);
        exp_t        e;
        logic [15:0] o16;
        logic [25:0] o26;
        int          off16;
        int          off26;
        bit          taken;
        o16   = inst[25:10];
        o26   = {inst[9:0], inst[25:10]};
        off16 = int'($signed(o16)) * 4;
        off26 = int'($signed(o26)) * 4;
        taken = 0;
        e.target  = pc + 32'(off16);
        e.wb_en   = 0;
        e.wb_addr = wa;
        e.wb_data = pc + 32'd4;
        if (op == ALU_BEQ)  taken = (rj == rd);
        if (op == ALU_BNE)  taken = (rj != rd);
        if (op == ALU_BLT)  taken = (int'(rj) < int'(rd));
        if (op == ALU_BGE)  taken = (int'(rj) >= int'(rd));
        if (op == ALU_BLTU) taken = (longint'({32'd0, rj}) < longint'({32'd0, rd}));
        if (op == ALU_BGEU) taken = (longint'({32'd0, rj}) >= longint'({32'd0, rd}));
        if (op == ALU_B || op == ALU_BL) begin
            taken    = 1;
            e.target = pc + 32'(off26);
        end
        if (op == ALU_BL) begin
            e.wb_en   = 1;
            e.wb_addr = 5'd1;
        end
        if (op == ALU_JIRL) begin
            taken    = 1;
            e.target = rj + 32'(off16);
            e.wb_en  = (wa != 0);
        end
        e.mp  = (taken != pt) || (taken && pt && e.target != ptgt);
        e.rpc = taken ? e.target : pc + 32'd4;
        return e;
    endfunction

    // Sole driver of the two downstream ready signals.
    initial begin
        bus.out_ready      = 1'b1;
        bus.redirect_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: begin
                    bus.out_ready      = ($urandom_range(0, 3) != 0);
                    bus.redirect_ready = ($urandom_range(0, 3) != 0);
                end
                1: begin
                    bus.out_ready      = 1'b1;
                    bus.redirect_ready = 1'b1;
                end
                2: begin
                    bus.out_ready      = 1'b1;
                    bus.redirect_ready = 1'b0;
                end
                default: begin
                    bus.out_ready      = 1'b0;
                    bus.redirect_ready = 1'b0;
                end
            endcase
        end
    end

    // Monitor: values sampled here are what the next rising edge will see.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (rst) begin
            res_q.delete();
            redir_q.delete();
            fresh = 0;
            checkOutput("in_ready_rst", bus.in_ready, 0);
            checkOutput("out_valid_rst", bus.out_valid, 0);
            checkOutput("redirect_valid_rst", bus.redirect_valid, 0);
`ifdef BRANCH_STAT_EN
            exp_bcnt = 0;
            exp_mcnt = 0;
            checkOutput("stat_branch_cnt_rst", stat_branch_cnt, 0);
`endif
        end else begin
            checkOutput("out_valid", bus.out_valid, res_q.size() != 0);
            checkOutput("redirect_valid", bus.redirect_valid, redir_q.size() != 0);
            checkOutput("out_mispredict", bus.out_mispredict,
                        (fresh && res_q.size() != 0) ? res_q[0].mp : 1'b0);
            if (bus.redirect_valid && redir_q.size() != 0)
                checkOutput("redirect_pc", bus.redirect_pc, redir_q[0]);
            exp_rdy = !flush && redir_q.size() == 0 &&
                      (res_q.size() == 0 || bus.out_ready);
            checkOutput("in_ready", bus.in_ready, exp_rdy);
`ifdef BRANCH_STAT_EN
            checkOutput("stat_branch_cnt", stat_branch_cnt, exp_bcnt);
            checkOutput("stat_mispredict_cnt", stat_mispredict_cnt, exp_mcnt);
`endif
            fresh = 0;
            if (flush) begin
                res_q.delete();
                redir_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && res_q.size() != 0) begin
                    e = res_q.pop_front();
                    checkOutput("out_wb_en", bus.out_wb_en, e.wb_en);
                    if (e.wb_en) begin
                        checkOutput("out_wb_addr", bus.out_wb_addr, e.wb_addr);
                        checkOutput("out_wb_data", bus.out_wb_data, e.wb_data);
                    end
                end
                if (bus.redirect_valid && bus.redirect_ready && redir_q.size() != 0)
                    void'(redir_q.pop_front());
                if (bus.in_valid && bus.in_ready) begin
                    e = model(bus.in_pc, bus.in_inst, bus.in_aluop, bus.in_rj_data,
                              bus.in_rd_data, bus.in_wb_addr, bus.in_pred_taken,
                              bus.in_pred_target);
                    res_q.push_back(e);
                    if (e.mp) redir_q.push_back(e.rpc);
                    fresh = 1;
`ifdef BRANCH_STAT_EN
                    exp_bcnt = exp_bcnt + 1;
                    if (e.mp) exp_mcnt = exp_mcnt + 1;
`endif
                end
            end
        end
    end

    // Holds one branch on the issue slot until it is accepted (bounded).
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [7:0] op, input logic [31:0] rj,
                                 input logic [31:0] rd, input logic [4:0] wa,
                                 input logic pt, input logic [31:0] ptgt,
                                 output int waited);
        bit accepted;
        bus.in_valid       = 1'b1;
        bus.in_pc          = pc;
        bus.in_inst        = inst;
        bus.in_aluop       = op;
        bus.in_rj_data     = rj;
        bus.in_rd_data     = rd;
        bus.in_wb_addr     = wa;
        bus.in_pred_taken  = pt;
        bus.in_pred_target = ptgt;
        accepted = 0;
        waited   = 0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            if (!accepted) waited++;
        end
        bus.in_valid = 1'b0;
        checkOutput("issue_accepted", accepted, 1);
    endtask

    function automatic logic [7:0] pickOp(input int k);
        case (k)
            0: return ALU_BEQ;
            1: return ALU_BNE;
            2: return ALU_BLT;
            3: return ALU_BGE;
            4: return ALU_BLTU;
            5: return ALU_BGEU;
            6: return ALU_B;
            7: return ALU_BL;
            8: return ALU_JIRL;
            default: return 8'h00;
        endcase
    endfunction

    task automatic randomIssue();
        logic [31:0] pc, inst, rj, rd, ptgt;
        logic [7:0]  op;
        logic [4:0]  wa;
        logic        pt;
        exp_t        e;
        int          w;
        pc   = $urandom() & 32'hFFFF_FFFC;
        inst = $urandom();
        op   = pickOp($urandom_range(0, 9));
        rj   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
        rd   = ($urandom_range(0, 3) == 0) ? rj : $urandom();
        wa   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pt   = 1'($urandom_range(0, 1));
        e    = model(pc, inst, op, rj, rd, wa, pt, 32'd0);
        ptgt = ($urandom_range(0, 3) != 0) ? e.target : $urandom();
        applyStimulus(pc, inst, op, rj, rd, wa, pt, ptgt, w);
    endtask

    initial begin
        int w;
        rst                = 1'b1;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_inst        = '0;
        bus.in_aluop       = '0;
        bus.in_rj_data     = '0;
        bus.in_rd_data     = '0;
        bus.in_wb_addr     = '0;
        bus.in_pred_taken  = 1'b0;
        bus.in_pred_target = '0;
        #1;
        checkOutput("rst_out_wb_en", bus.out_wb_en, 0);
        checkOutput("rst_out_mispredict", bus.out_mispredict, 0);
        checkOutput("rst_out_wb_addr", bus.out_wb_addr, 0);
        checkOutput("rst_out_wb_data", bus.out_wb_data, 0);
        checkOutput("rst_redirect_pc", bus.redirect_pc, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back correctly predicted B instructions.
        rdy_mode = 1;
        applyStimulus(32'h200, 32'h0000_1000, ALU_B, 0, 0, 0, 1, 32'h210, w);
        applyStimulus(32'h210, 32'h0000_1000, ALU_B, 0, 0, 0, 1, 32'h220, w);
        checkOutput("b2b_no_stall", w, 0);
        checkOutput("b2b_out_valid", bus.out_valid, 1);
`ifdef BRANCH_STAT_EN
        checkOutput("b2b_stat_branch", stat_branch_cnt, 2);
        checkOutput("b2b_stat_mispredict", stat_mispredict_cnt, 0);
`endif

        // BEQ taken but predicted not taken.
        applyStimulus(32'h1C00_0000, 32'h0000_1000, ALU_BEQ, 5, 5, 0, 0, 0, w);
        checkOutput("beq_redirect_valid", bus.redirect_valid, 1);
        checkOutput("beq_redirect_pc", bus.redirect_pc, 32'h1C00_0010);
        checkOutput("beq_mispredict", bus.out_mispredict, 1);

        // Signed vs unsigned compare of the same operands.
        applyStimulus(32'h1000, 32'h0000_2000, ALU_BLT, 32'hFFFF_FFFF, 1, 0, 1, 32'h1020, w);
        checkOutput("blt_redirect_valid", bus.redirect_valid, 0);
        checkOutput("blt_mispredict", bus.out_mispredict, 0);
        applyStimulus(32'h1000, 32'h0000_2000, ALU_BLTU, 32'hFFFF_FFFF, 1, 0, 1, 32'h1020, w);
        checkOutput("bltu_redirect_valid", bus.redirect_valid, 1);
        checkOutput("bltu_redirect_pc", bus.redirect_pc, 32'h1004);

        // JIRL with negative offset wrapping below 0x80000000.
        applyStimulus(32'h100, 32'h03FF_FC00, ALU_JIRL, 32'h8000_0000, 0, 1, 1, 32'h7FFF_FFFC, w);
        checkOutput("jirl_redirect_valid", bus.redirect_valid, 0);
        checkOutput("jirl_wb_en", bus.out_wb_en, 1);
        checkOutput("jirl_wb_addr", bus.out_wb_addr, 1);
        checkOutput("jirl_wb_data", bus.out_wb_data, 32'h104);

        // Redirect held off for three cycles.
        rdy_mode = 2;
        applyStimulus(32'h3000, 32'h0000_1000, ALU_BEQ, 1, 2, 0, 1, 32'h3010, w);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_redirect_valid", bus.redirect_valid, 1);
            checkOutput("hold_redirect_pc", bus.redirect_pc, 32'h3004);
            checkOutput("hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        checkOutput("release_in_ready", bus.in_ready, 1);
        checkOutput("release_redirect_valid", bus.redirect_valid, 0);

        // Flush with a pending redirect and a branch on the issue slot.
        @(posedge clk);
        #1;
        rdy_mode = 2;
        applyStimulus(32'h4000, 32'h0000_1000, ALU_BEQ, 1, 2, 0, 1, 32'h4010, w);
        flush              = 1'b1;
        bus.in_valid       = 1'b1;
        bus.in_pc          = 32'h5000;
        bus.in_inst        = 32'h0000_1000;
        bus.in_aluop       = ALU_B;
        bus.in_pred_taken  = 1'b0;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("flush_out_valid", bus.out_valid, 0);
            checkOutput("flush_redirect_valid", bus.redirect_valid, 0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with bubbles and occasional flushes.
        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 4) begin
                @(posedge clk);
                #1;
            end else if (r == 4) begin
                flush        = 1'b1;
                bus.in_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                flush        = 1'b0;
                bus.in_valid = 1'b0;
            end else begin
                randomIssue();
            end
        end

        // Drain everything still pending.
        rdy_mode = 1;
        for (int i = 0; i < 50 && (res_q.size() != 0 || redir_q.size() != 0); i++)
            @(posedge clk);
        #1;
        checkOutput("drain_empty", res_q.size() + redir_q.size(), 0);

        // Reset while a result and redirect are in flight.
        rdy_mode = 3;
        @(posedge clk);
        #1;
        applyStimulus(32'h6000, 32'h0000_1000, ALU_B, 0, 0, 0, 0, 0, w);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_redirect_valid", bus.redirect_valid, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        checkOutput("midrst_mispredict", bus.out_mispredict, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        checkOutput("post_rst_out_valid", bus.out_valid, 0);
        checkOutput("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have `clk`  in  1  single clock, all state on rising edge.
REQ-002 SHALL have `rst`  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have the following ports; `in_valid`/`in_ready` is the issue handshake.
- `in_valid`  in  1  issue slot holds a decoded branch.
- `in_ready`  out  1  unit can accept.
- `in_pc`  in  32  branch PC.
- `in_inst`  in  32  raw instruction; offs16=inst[25:10], offs26={inst[9:0],inst[25:10]}.
- `in_aluop`  in  8  ALU_BEQ/BNE/BLT/BGE/BLTU/BGEU/B/BL/JIRL codes from defines.vh.
- `in_rj_data`, `in_rd_data`  in  32 each  operand values (reg1/reg2 read ports).
- `in_wb_addr`  in  5  link destination.
- `in_pred_taken`  in  1  fetch prediction.
- `in_pred_target`  in  32  predicted target.
- `flush`  in  1  kill everything.
REQ-004 SHALL have the following result and redirect ports.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  writeback accepts.
- `out_wb_en`  out  1  link write.
- `out_wb_addr`  out  5.
- `out_wb_data`  out  32  link value.
- `redirect_valid`  out  1  fetch redirect pending.
- `redirect_ready`  in  1  fetch accepts.
- `redirect_pc`  out  32.
- `out_mispredict`  out  1.

Function
REQ-005 SHALL accept on `in_valid & in_ready` and register all results; latency is exactly 1 cycle to `out_valid`.
REQ-006 SHALL drive `in_ready = !flush & !redirect_valid & (!out_valid | out_ready)`.
REQ-007 SHALL resolve the branch direction as follows.
- BEQ/BNE: rj==rd / rj!=rd.
- BLT/BGE: signed rj<rd / rj>=rd.
- BLTU/BGEU: unsigned compares.
- B/BL/JIRL: always taken.
- Any other aluop: not taken, no writeback.
REQ-008 SHALL compute the branch target as follows, with all additions mod 2^32.
- Conditional branches: pc + sext({offs16,2'b00}).
- B/BL: pc + sext({offs26,2'b00}).
- JIRL: rj + sext({offs16,2'b00}).
REQ-009 SHALL set `out_wb_en=1` with `out_wb_data=pc+4` for BL (addr 1) and JIRL (addr in_wb_addr), and `out_wb_en=0` otherwise.
- An rd=0 writeback SHALL be suppressed (`wb_en=0`).
REQ-010 SHALL flag mispredict when actual_taken != in_pred_taken, or when both are taken and target != in_pred_target.
- `redirect_pc` = target if taken, else pc+4.
REQ-011 SHALL use FSM states IDLE, RESULT, REDIR with the following transitions.
- IDLE→RESULT on accept without mispredict.
- IDLE→REDIR on accept with mispredict.
- RESULT→IDLE on out_ready with no new accept; RESULT stays on back-to-back accept.
- REDIR→IDLE when both the redirect and the result are consumed.
REQ-012 SHALL hold `redirect_valid` and `redirect_pc` stable until `redirect_ready`; `out_valid` and `redirect_valid` handshakes are independent and either may complete first.
REQ-013 SHALL give `flush` priority over all handshakes: next cycle out_valid=0, redirect_valid=0, state=IDLE, and an incoming instruction in the same cycle is dropped.
REQ-014 SHALL pulse `out_mispredict` for one cycle, aligned with the first cycle of `out_valid`.

Reset
REQ-015 SHALL on rst force state=IDLE and set out_valid, redirect_valid, out_wb_en, and out_mispredict to 0.
- out_wb_addr, out_wb_data, and redirect_pc SHALL reset to 0.
REQ-016 SHALL discard any in-flight result when rst asserts mid-operation, and drive in_ready=0 while rst is high.

Configuration
REQ-017 SHALL, with macro BRANCH_STAT_EN defined, add output ports `stat_branch_cnt[31:0]` and `stat_mispredict_cnt[31:0]`.
- The counters SHALL increment on each accepted branch and each mispredict respectively, wrap at 2^32, clear on rst, and not be cleared by flush.
- Without the macro, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-018 SHALL pass: BEQ pc=0x1C000000, offs16=0x0004, rj=rd=5, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x1C000010, out_mispredict=1.
REQ-019 SHALL pass: BLT rj=0xFFFFFFFF, rd=1, pred_taken=1, pred_target correct -> taken, no redirect; the same operands with BLTU -> not taken, redirect to pc+4.
REQ-020 SHALL pass: JIRL rj=0x80000000, offs16=0xFFFF, rd=1, pc=0x100 -> target 0x7FFFFFFC, wb_en=1, wb_addr=1, wb_data=0x104.
REQ-021 SHALL pass: redirect_ready held 0 for 3 cycles -> redirect_pc stable and in_ready=0 throughout; after ready, IDLE and in_ready=1.
REQ-022 SHALL pass: flush asserted with in_valid=1 and a pending redirect -> next cycle out_valid=0, redirect_valid=0, and the new branch never appears.
REQ-023 SHALL pass: back-to-back B instructions with out_ready=1 and correct predictions -> one result per cycle; with BRANCH_STAT_EN, stat_branch_cnt=2 and stat_mispredict_cnt=0.
